// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline stall controller.
// Holds the FSM state encoding, the default watchdog/counter sizes and the
// packed control bundle used inside the controller.
package pipeline_stall_ctrl_pkg;

    typedef enum logic {
        STATE_RUN      = 1'b0,
        STATE_MEM_WAIT = 1'b1
    } state_e;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 16;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic flush_if_id;
        logic bubble_id_exe;
        logic freeze_back;
    } ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, never wraps.
// Latency: count visible one cycle after the increment request.
// Ports: clk_i, rst_ni (async active-low), inc_i, cnt_o[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/bubble controller for the 5-stage MIPS pipeline, with memory wait watchdog.
// Latency: all controls combinational from state and inputs (zero cycles); mem_error registered.
// Backpressure: data memory wait states freeze the whole pipeline until mem_ready or timeout.
// Ports: clk, rst (async active-low), hazard_detected, branch_taken, mem_req, mem_ready in;
//        freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_back, mem_error,
//        stall_cycles, flush_count out. Optional counters enabled by STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_back,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_error_q, mem_error_d;
    ctrl_t             ctrl;
    ctrl_t             ctrl_g;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_error_d = mem_error_q;
        ctrl        = '0;
        case (state_q)
            STATE_RUN: begin
                wcnt_d = '0;
                if (mem_req && !mem_ready) begin
                    ctrl.freeze_pc    = 1'b1;
                    ctrl.freeze_if_id = 1'b1;
                    ctrl.freeze_back  = 1'b1;
                    state_d           = STATE_MEM_WAIT;
                    wcnt_d            = WCNT_W'(1);
                end else if (hazard_detected) begin
                    // Branch operands are not valid yet, so a taken branch is ignored here.
                    ctrl.freeze_pc     = 1'b1;
                    ctrl.freeze_if_id  = 1'b1;
                    ctrl.bubble_id_exe = 1'b1;
                end else if (branch_taken) begin
                    ctrl.flush_if_id = 1'b1;
                end
            end
            STATE_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = STATE_RUN;
                    wcnt_d  = '0;
                end else begin
                    ctrl.freeze_pc    = 1'b1;
                    ctrl.freeze_if_id = 1'b1;
                    ctrl.freeze_back  = 1'b1;
                    // wcnt_q counts wait cycles already spent; this cycle is the next one.
                    if ((32'(wcnt_q) + 32'd1) >= 32'(MEM_TIMEOUT)) begin
                        mem_error_d = 1'b1;
                        state_d     = STATE_RUN;
                        wcnt_d      = '0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            default: state_d = STATE_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= STATE_RUN;
            wcnt_q      <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Controls are forced low while reset is held, even though inputs may request a stall.
    assign ctrl_g        = rst ? ctrl : '0;
    assign freeze_pc     = ctrl_g.freeze_pc;
    assign freeze_if_id  = ctrl_g.freeze_if_id;
    assign flush_if_id   = ctrl_g.flush_if_id;
    assign bubble_id_exe = ctrl_g.bubble_id_exe;
    assign freeze_back   = ctrl_g.freeze_back;
    assign mem_error     = mem_error_q;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (ctrl_g.freeze_pc),
        .cnt_o  (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (ctrl_g.flush_if_id),
        .cnt_o  (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the hazard-detection result and the branch/memory status of the 5-stage MIPS pipeline.
- Drives the freeze, flush and bubble controls for the PC and the pipeline registers.
- Holds the whole pipeline while data memory inserts wait states.
- Runs a wait-state watchdog, and optionally keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before mem_error is raised.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- hazard_detected  input  1  ID-stage data hazard requiring a stall
- branch_taken  input  1  branch in ID resolved as taken this cycle
- mem_req  input  1  MEM stage performs a load or store this cycle
- mem_ready  input  1  data memory completes the access this cycle
- freeze_pc  output  1  hold PC
- freeze_if_id  output  1  hold the IF/ID register
- flush_if_id  output  1  clear the IF/ID register to NOP
- bubble_id_exe  output  1  load NOP into the ID/EXE register
- freeze_back  output  1  hold the ID/EXE, EXE/MEM and MEM/WB registers
- mem_error  output  1  sticky watchdog error
- stall_cycles  output  CNT_W  hazard plus memory stall cycles (optional feature)
- flush_count  output  CNT_W  taken-branch flushes (optional feature)

Behaviour:
States and transitions:
- The FSM has two states: RUN and MEM_WAIT.
- The state register and wait counter are clocked.
- All control outputs are combinational from state and inputs, so they take effect in the same cycle (zero latency).

Reset:
- On rst low, asynchronously: state = RUN, wait counter = 0, mem_error = 0, counters = 0.
- While in reset, every control output is 0.

RUN state, decoded in priority order:
1. mem_req=1 and mem_ready=0:
   - freeze_pc = freeze_if_id = freeze_back = 1, all other controls 0.
   - Next state is MEM_WAIT and the wait counter loads 1.
2. hazard_detected=1:
   - freeze_pc = freeze_if_id = 1 and bubble_id_exe = 1.
   - branch_taken is ignored, because its operands are not yet valid.
3. branch_taken=1:
   - flush_if_id = 1 for exactly that cycle; the PC loads the target (no freeze).
4. Otherwise: all controls are 0.

MEM_WAIT state:
- While mem_ready=0: freeze_pc = freeze_if_id = freeze_back = 1 and the wait counter increments.
- hazard_detected and branch_taken are ignored; the frozen instructions re-present them later.
- mem_ready=1: all controls are 0 this cycle and the next state is RUN.
- Wait counter reaching MEM_TIMEOUT while mem_ready=0:
  - mem_error is set (sticky until reset) and the next state is RUN.
  - freeze_back is held for the current cycle.
- mem_ready and the timeout in the same cycle: mem_ready wins and mem_error is not set.

Boundary rules:
- mem_req=1 with mem_ready=1 in RUN causes no stall.
- The wait counter is wide enough for MEM_TIMEOUT and clears on entry to RUN.
- Reset asserted mid-MEM_WAIT forces RUN immediately; no stale freeze is asserted after reset release.
- flush_if_id and freeze_if_id are never 1 together.
- bubble_id_exe and freeze_back are never 1 together.

Optional Feature:
Macro: STALL_PERF_CNT_EN
- Defined:
  - stall_cycles increments on every cycle in which freeze_pc=1.
  - flush_count increments on every cycle in which flush_if_id=1.
  - Both counters saturate at all-ones and never wrap; both reset to 0.
- Undefined: the counter logic is absent and both outputs are tied to 0.

Decomposition:
- Shared defines header holds:
  - state encodings: STATE_RUN = 1'b0, STATE_MEM_WAIT = 1'b1;
  - the default MEM_TIMEOUT;
  - the default CNT_W.
- One natural sub-module, sat_counter:
  - parameterised width;
  - inc and asynchronous active-low reset;
  - holds at maximum;
  - instantiated twice under STALL_PERF_CNT_EN.

Test Plan:
1. Reset behaviour: rst=0 while mem_req=1 and mem_ready=0 → all outputs 0. Release rst → in that cycle freeze_back=1 and the state reaches MEM_WAIT at the next edge.
2. Hazard stall: hazard_detected=1 for 2 cycles → freeze_pc=freeze_if_id=bubble_id_exe=1 for exactly those 2 cycles, flush_if_id=0. With the macro, stall_cycles=2.
3. Hazard plus branch in the same cycle: hazard_detected=1 and branch_taken=1 → stall only, flush_if_id=0. Next cycle branch_taken=1 alone → flush_if_id=1 and flush_count=1.
4. Memory wait states: mem_req=1 with mem_ready low for 3 cycles, then high → freeze_back=1 for 3 cycles and 0 on the 4th; branch_taken pulsed during the wait → no flush.
5. Watchdog: MEM_TIMEOUT=4 and mem_ready held 0 → mem_error rises after the 4th wait cycle and stays 1 through later normal traffic until rst is pulsed.
6. Counter saturation: CNT_W=4 and 20 stall cycles → stall_cycles=15. Macro undefined → stall_cycles=0 and flush_count=0 always.
